// File: rtl/fast_control_scheduler_pkg.sv
// Shared fast-control definitions: sequencer state encodings and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fast_control_scheduler_pkg;

  localparam int ORBIT_LEN_DEF = 3564;  // BX per LHC orbit
  localparam int BX_W_DEF      = 12;
  localparam int PS_W_DEF      = 8;
  localparam int RST_LEN_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RST  = 2'd2,
    ST_ACK  = 2'd3
  } fc_state_t;

endpackage

// File: rtl/fast_control_scheduler_bx_orbit_counter.sv
// BX counter over one orbit, orbit wrap flag and WTE orbit-prescale counter.
// Latency: bx_count/ps_cnt update on the clock edge after clear/run; orbit_tick is combinational.
// Backpressure: none; clear has priority over run, neither holds the count.
module fast_control_scheduler_bx_orbit_counter
  import fast_control_scheduler_pkg::*;
#(
  parameter int ORBIT_LEN = ORBIT_LEN_DEF,
  parameter int BX_W      = BX_W_DEF,
  parameter int PS_W      = PS_W_DEF
) (
  input  logic            clk_in,
  input  logic            reset_in_n,
  input  logic            clear,
  input  logic            run,
  input  logic [PS_W-1:0] wte_prescale,
  output logic [BX_W-1:0] bx_count,
  output logic            orbit_tick,
  output logic [PS_W-1:0] ps_cnt
);

  logic wrap;
  logic ps_last;

  assign wrap       = (bx_count == BX_W'(ORBIT_LEN - 1));
  assign orbit_tick = wrap;
  // A zero prescale means WTE is off; keep ps_cnt parked at 0 in that case.
  assign ps_last    = (wte_prescale == '0) || (ps_cnt >= wte_prescale - PS_W'(1));

  // Advance BX every cycle while running; step the prescale counter once per orbit.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      bx_count <= '0;
      ps_cnt   <= '0;
    end else if (clear) begin
      bx_count <= '0;
      ps_cnt   <= '0;
    end else if (run) begin
      if (wrap) begin
        bx_count <= '0;
        ps_cnt   <= ps_last ? '0 : ps_cnt + PS_W'(1);
      end else begin
        bx_count <= bx_count + BX_W'(1);
      end
    end
  end

endmodule

// File: rtl/fast_control_scheduler.sv
// Fast-control sequencer: orbit-scheduled QIE-reset/WTE pulses and req/ack chip reset.
// Latency: pulses 1 cycle after the BX match; reset_out/rst_ack follow the state register.
// Backpressure: none; rst_req/rst_ack is a 4-phase handshake, ack held until req drops.
module fast_control_scheduler
  import fast_control_scheduler_pkg::*;
#(
  parameter int ORBIT_LEN = ORBIT_LEN_DEF,
  parameter int BX_W      = BX_W_DEF,
  parameter int PS_W      = PS_W_DEF,
  parameter int RST_LEN   = RST_LEN_DEF
) (
  input  logic            clk_in,
  input  logic            reset_in_n,
  input  logic            enable,
  input  logic [BX_W-1:0] qrst_bx,
  input  logic [BX_W-1:0] wte_bx,
  input  logic [PS_W-1:0] wte_prescale,
  input  logic            rst_req,
  output logic            rst_ack,
  output logic            qie_reset_out,
  output logic            wte_out,
  output logic            reset_out,
  output logic            orbit_tick,
  output logic [BX_W-1:0] bx_count
);

  localparam int RC_W = $clog2(RST_LEN + 1);

  fc_state_t       state, state_nxt;
  logic [RC_W-1:0] rst_cnt;
  logic            rst_done;
  logic [PS_W-1:0] ps_cnt;
  logic            cnt_clear;
  logic            cnt_run;
  logic            pulse_ok;
  logic            qrst_hit;
  logic            wte_hit;

  assign rst_done  = (rst_cnt == RC_W'(RST_LEN - 1));
  // Anything other than staying in RUN restarts the orbit from BX 0 / ps_cnt 0.
  assign cnt_clear = (state_nxt != ST_RUN);
  assign cnt_run   = (state == ST_RUN);

  fast_control_scheduler_bx_orbit_counter #(
    .ORBIT_LEN (ORBIT_LEN),
    .BX_W      (BX_W),
    .PS_W      (PS_W)
  ) u_bx_orbit_counter (
    .clk_in       (clk_in),
    .reset_in_n   (reset_in_n),
    .clear        (cnt_clear),
    .run          (cnt_run),
    .wte_prescale (wte_prescale),
    .bx_count     (bx_count),
    .orbit_tick   (orbit_tick),
    .ps_cnt       (ps_cnt)
  );

  // State register.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state and Moore outputs; a chip-reset request beats enable in every state.
  always_comb begin
    state_nxt = state;
    reset_out = 1'b0;
    rst_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_req)     state_nxt = ST_RST;
        else if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (rst_req)      state_nxt = ST_RST;
        else if (!enable) state_nxt = ST_IDLE;
      end
      ST_RST: begin
        reset_out = 1'b1;
        if (rst_done) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        rst_ack = 1'b1;
        if (!rst_req) state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Count cycles spent in RST to size the chip-reset pulse.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n)          rst_cnt <= '0;
    else if (state != ST_RST) rst_cnt <= '0;
    else                      rst_cnt <= rst_cnt + RC_W'(1);
  end

  // A match in the cycle that leaves for RST would land inside reset_out, so it is dropped.
  assign pulse_ok = (state == ST_RUN) && !rst_req;
  assign qrst_hit = pulse_ok && (bx_count == qrst_bx);
  // QIE reset wins a BX collision; the WTE for that orbit is lost, not deferred.
  assign wte_hit  = pulse_ok && (bx_count == wte_bx) && (ps_cnt == '0) &&
                    (wte_prescale != '0) && (qrst_bx != wte_bx);

  // Register the match results into single-cycle output pulses.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      qie_reset_out <= 1'b0;
      wte_out       <= 1'b0;
    end else begin
      qie_reset_out <= qrst_hit;
      wte_out       <= wte_hit;
    end
  end

endmodule

// File: tb/tb_fast_control_scheduler.sv
// Self-checking bench for fast_control_scheduler: pulse scoreboard plus inline checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_fast_control_scheduler;

  localparam int L = 3564;

  typedef struct {
    int kind;  // 0 = qie_reset_out, 1 = wte_out
    int cyc;
    int bx;
  } ev_t;

  logic        clk_in = 1'b0;
  logic        reset_in_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] qrst_bx = 12'd4000;
  logic [11:0] wte_bx = 12'd4000;
  logic [7:0]  wte_prescale = 8'd0;
  logic        rst_req = 1'b0;
  logic        rst_ack;
  logic        qie_reset_out;
  logic        wte_out;
  logic        reset_out;
  logic        orbit_tick;
  logic [11:0] bx_count;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  fast_control_scheduler dut (
    .clk_in        (clk_in),
    .reset_in_n    (reset_in_n),
    .enable        (enable),
    .qrst_bx       (qrst_bx),
    .wte_bx        (wte_bx),
    .wte_prescale  (wte_prescale),
    .rst_req       (rst_req),
    .rst_ack       (rst_ack),
    .qie_reset_out (qie_reset_out),
    .wte_out       (wte_out),
    .reset_out     (reset_out),
    .orbit_tick    (orbit_tick),
    .bx_count      (bx_count)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every pulse the DUT produces, tagged with cycle and current BX.
  always @(negedge clk_in) begin
    ev_t o;
    if (qie_reset_out) begin
      o.kind = 0; o.cyc = cyc; o.bx = int'(bx_count);
      obs_q.push_back(o);
    end
    if (wte_out) begin
      o.kind = 1; o.cyc = cyc; o.bx = int'(bx_count);
      obs_q.push_back(o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push_ev(input int k, input int c, input int b);
    ev_t e;
    e.kind = k; e.cyc = c; e.bx = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    step(3);
    checks += 6;
    if (qie_reset_out !== 1'b0) begin failures++; $display("FAIL rst_qie got=%b exp=0", qie_reset_out); end
    if (wte_out !== 1'b0)       begin failures++; $display("FAIL rst_wte got=%b exp=0", wte_out); end
    if (reset_out !== 1'b0)     begin failures++; $display("FAIL rst_reset_out got=%b exp=0", reset_out); end
    if (rst_ack !== 1'b0)       begin failures++; $display("FAIL rst_ack got=%b exp=0", rst_ack); end
    if (orbit_tick !== 1'b0)    begin failures++; $display("FAIL rst_tick got=%b exp=0", orbit_tick); end
    if (bx_count !== 12'd0)     begin failures++; $display("FAIL rst_bx got=%0d exp=0", bx_count); end
    reset_in_n = 1'b1;
    step(3);
    checks++;
    if (bx_count !== 12'd0) begin failures++; $display("FAIL idle_bx got=%0d exp=0", bx_count); end
  endtask

  task automatic test_basic();
    int  t0;
    ev_t o, e;
    qrst_bx = 12'd5; wte_bx = 12'd100; wte_prescale = 8'd1;
    enable = 1'b1;
    t0 = cyc + 1;
    for (int n = 0; n < 2; n++) begin
      push_ev(0, t0 + n*L + 6, 6);
      push_ev(1, t0 + n*L + 101, 101);
    end
    goto_cyc(t0 + L - 2);
    checks++;
    if (orbit_tick !== 1'b0) begin failures++; $display("FAIL tick_before got=%b exp=0", orbit_tick); end
    goto_cyc(t0 + L - 1);
    checks += 2;
    if (orbit_tick !== 1'b1) begin failures++; $display("FAIL tick_at_end got=%b exp=1", orbit_tick); end
    if (bx_count !== 12'(L - 1)) begin failures++; $display("FAIL bx_last got=%0d exp=%0d", bx_count, L - 1); end
    goto_cyc(t0 + L);
    checks += 2;
    if (orbit_tick !== 1'b0) begin failures++; $display("FAIL tick_after_wrap got=%b exp=0", orbit_tick); end
    if (bx_count !== 12'd0)  begin failures++; $display("FAIL bx_wrap got=%0d exp=0", bx_count); end
    goto_cyc(t0 + 2*L - 1);
    checks++;
    if (orbit_tick !== 1'b1) begin failures++; $display("FAIL tick_period got=%b exp=1", orbit_tick); end
    goto_cyc(t0 + 2*L + 2);
    enable = 1'b0;
    goto_cyc(t0 + 2*L + 3);
    checks++;
    if (bx_count !== 12'd0) begin failures++; $display("FAIL disable_bx got=%0d exp=0", bx_count); end
    goto_cyc(t0 + 2*L + 8);
    checks++;
    if (bx_count !== 12'd0) begin failures++; $display("FAIL idle_hold_bx got=%0d exp=0", bx_count); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL basic_unexpected kind=%0d cyc=%0d bx=%0d", o.kind, o.cyc, o.bx);
      end else begin
        e = exp_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc || o.bx !== e.bx) begin
          failures++;
          $display("FAIL basic_pulse got kind=%0d cyc=%0d bx=%0d exp kind=%0d cyc=%0d bx=%0d",
                   o.kind, o.cyc, o.bx, e.kind, e.cyc, e.bx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=0 exp=%0d", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_prescale();
    int  t0;
    ev_t o, e;
    qrst_bx = 12'd4000; wte_bx = 12'd100; wte_prescale = 8'd3;
    enable = 1'b1;
    t0 = cyc + 1;
    // Prescale 3 gives orbits 0 and 3; switching to 2 during orbit 3 gives orbit 5 next.
    push_ev(1, t0 + 0*L + 101, 101);
    push_ev(1, t0 + 3*L + 101, 101);
    push_ev(1, t0 + 5*L + 101, 101);
    goto_cyc(t0 + 3*L + 2000);
    wte_prescale = 8'd2;
    goto_cyc(t0 + 6*L + 200);
    enable = 1'b0;
    step(2);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL prescale_unexpected kind=%0d cyc=%0d bx=%0d", o.kind, o.cyc, o.bx);
      end else begin
        e = exp_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc || o.bx !== e.bx) begin
          failures++;
          $display("FAIL prescale_pulse got kind=%0d cyc=%0d bx=%0d exp kind=%0d cyc=%0d bx=%0d",
                   o.kind, o.cyc, o.bx, e.kind, e.cyc, e.bx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL prescale_missing got=0 exp=%0d", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_collision();
    int  t0;
    ev_t o, e;
    qrst_bx = 12'd40; wte_bx = 12'd40; wte_prescale = 8'd1;
    enable = 1'b1;
    t0 = cyc + 1;
    push_ev(0, t0 + 41, 41);
    push_ev(0, t0 + L + 41, 41);
    // enable drops on the matching BX of orbit 2: the pulse still lands, now in IDLE.
    push_ev(0, t0 + 2*L + 41, 0);
    goto_cyc(t0 + 2*L + 40);
    enable = 1'b0;
    goto_cyc(t0 + 2*L + 45);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL collide_unexpected kind=%0d cyc=%0d bx=%0d", o.kind, o.cyc, o.bx);
      end else begin
        e = exp_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc || o.bx !== e.bx) begin
          failures++;
          $display("FAIL collide_pulse got kind=%0d cyc=%0d bx=%0d exp kind=%0d cyc=%0d bx=%0d",
                   o.kind, o.cyc, o.bx, e.kind, e.cyc, e.bx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL collide_missing got=0 exp=%0d", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_chip_reset();
    int  t0, t1, n_hi;
    ev_t o, e;
    qrst_bx = 12'd5; wte_bx = 12'd4000; wte_prescale = 8'd1;
    enable = 1'b1;
    t0 = cyc + 1;
    push_ev(0, t0 + 6, 6);
    goto_cyc(t0 + 200);
    checks++;
    if (bx_count !== 12'd200) begin failures++; $display("FAIL req_bx got=%0d exp=200", bx_count); end
    rst_req = 1'b1;
    n_hi = 0;
    for (int c = t0 + 200; c <= t0 + 224; c++) begin
      goto_cyc(c);
      if (reset_out === 1'b1) n_hi++;
    end
    checks++;
    if (n_hi != 16) begin failures++; $display("FAIL reset_len got=%0d exp=16", n_hi); end
    goto_cyc(t0 + 225);
    checks += 3;
    if (rst_ack !== 1'b1)   begin failures++; $display("FAIL ack_held got=%b exp=1", rst_ack); end
    if (reset_out !== 1'b0) begin failures++; $display("FAIL reset_in_ack got=%b exp=0", reset_out); end
    if (bx_count !== 12'd0) begin failures++; $display("FAIL bx_in_ack got=%0d exp=0", bx_count); end
    rst_req = 1'b0;
    goto_cyc(t0 + 226);
    t1 = t0 + 226;
    checks += 2;
    if (rst_ack !== 1'b0)   begin failures++; $display("FAIL ack_drop got=%b exp=0", rst_ack); end
    if (bx_count !== 12'd0) begin failures++; $display("FAIL resync_bx got=%0d exp=0", bx_count); end
    push_ev(0, t1 + 6, 6);
    goto_cyc(t1 + 10);
    checks++;
    if (bx_count !== 12'd10) begin failures++; $display("FAIL resync_run_bx got=%0d exp=10", bx_count); end
    goto_cyc(t1 + 12);
    enable = 1'b0;
    step(2);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL chiprst_unexpected kind=%0d cyc=%0d bx=%0d", o.kind, o.cyc, o.bx);
      end else begin
        e = exp_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc || o.bx !== e.bx) begin
          failures++;
          $display("FAIL chiprst_pulse got kind=%0d cyc=%0d bx=%0d exp kind=%0d cyc=%0d bx=%0d",
                   o.kind, o.cyc, o.bx, e.kind, e.cyc, e.bx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL chiprst_missing got=0 exp=%0d", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    int t0;
    qrst_bx = 12'd10; wte_bx = 12'd4000; wte_prescale = 8'd1;
    enable = 1'b1;
    t0 = cyc + 1;
    goto_cyc(t0 + 11);
    checks++;
    if (qie_reset_out !== 1'b1) begin failures++; $display("FAIL inflight_pulse got=%b exp=1", qie_reset_out); end
    #1 reset_in_n = 1'b0;
    #1;
    checks++;
    if (qie_reset_out !== 1'b0) begin failures++; $display("FAIL pulse_killed got=%b exp=0", qie_reset_out); end
    enable = 1'b0;
    step(2);
    reset_in_n = 1'b1;
    step(1);
    qrst_bx = 12'd4000;
    enable = 1'b1;
    t0 = cyc + 1;
    goto_cyc(t0 + 50);
    rst_req = 1'b1;
    goto_cyc(t0 + 55);
    checks++;
    if (reset_out !== 1'b1) begin failures++; $display("FAIL reset_active got=%b exp=1", reset_out); end
    #1 reset_in_n = 1'b0;
    #1;
    checks += 3;
    if (reset_out !== 1'b0) begin failures++; $display("FAIL areset_reset_out got=%b exp=0", reset_out); end
    if (rst_ack !== 1'b0)   begin failures++; $display("FAIL areset_ack got=%b exp=0", rst_ack); end
    if (bx_count !== 12'd0) begin failures++; $display("FAIL areset_bx got=%0d exp=0", bx_count); end
    rst_req = 1'b0;
    enable = 1'b0;
    step(2);
    reset_in_n = 1'b1;
    step(3);
    checks += 2;
    if (reset_out !== 1'b0) begin failures++; $display("FAIL post_areset_reset_out got=%b exp=0", reset_out); end
    if (bx_count !== 12'd0) begin failures++; $display("FAIL post_areset_bx got=%0d exp=0", bx_count); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL areset_unexpected got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_wte_off();
    int t0, n_wte;
    qrst_bx = 12'd4000; wte_bx = 12'd100; wte_prescale = 8'd0;
    enable = 1'b1;
    t0 = cyc + 1;
    n_wte = 0;
    for (int c = t0; c < t0 + 2*L + 5; c++) begin
      goto_cyc(c);
      if (wte_out === 1'b1) n_wte++;
      if (c == t0 + L) begin
        wte_bx = 12'd4000;
        wte_prescale = 8'd1;
      end
    end
    checks++;
    if (n_wte != 0) begin failures++; $display("FAIL wte_off_count got=%0d exp=0", n_wte); end
    enable = 1'b0;
    step(1);
    checks++;
    if (bx_count !== 12'd0) begin failures++; $display("FAIL wte_off_disable_bx got=%0d exp=0", bx_count); end
    step(1);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL wte_off_unexpected got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_collision();
    test_chip_reset();
    test_async_reset();
    test_wte_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
